// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg : shared types and round-robin helpers for fifo_arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int MAX_NREQ = 16;
  localparam int MAX_IDW  = 4;

  // Wrap-around increment; the modulo is explicit so NREQ need not be 2^k.
  function automatic int rr_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // First set bit of vec at or after start, wrapping modulo n.
  function automatic int rr_next(input logic [MAX_NREQ-1:0] vec,
                                 input int start, input int n);
    int   idx;
    logic hit;
    hit     = 1'b0;
    idx     = start;
    rr_next = start;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (!hit && (i < n) && vec[idx[MAX_IDW-1:0]]) begin
        hit     = 1'b1;
        rr_next = idx;
      end
      idx = rr_inc(idx, n);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick : combinational round-robin search with optional excluded index.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  start,
  input  logic            excl_en,
  input  logic [IDW-1:0]  excl_idx,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  logic [MAX_NREQ-1:0] w_vec;
  logic [MAX_NREQ-1:0] w_masked;
  logic [MAX_IDW-1:0]  w_excl;

  assign w_excl = MAX_IDW'(excl_idx);

  // The excluded index is only a fallback: it wins when nobody else is valid.
  always_comb begin
    w_vec             = '0;
    w_vec[NREQ-1:0]   = req;
    w_masked          = w_vec;
    if (excl_en) begin
      w_masked[w_excl] = 1'b0;
    end
    found = 1'b0;
    idx   = '0;
    if (|w_masked) begin
      found = 1'b1;
      idx   = IDW'(rr_next(w_masked, int'(start), NREQ));
    end else if (excl_en && w_vec[w_excl]) begin
      found = 1'b1;
      idx   = excl_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_arbiter : round-robin burst arbiter pushing tagged words into one FIFO.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_arbiter
  import arb_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int DWIDTH   = 32,
  parameter  int MAXBURST = 4,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0][DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic                        fifo_push,
  output logic [IDW+DWIDTH-1:0]       fifo_in,
  input  logic                        fifo_full,
  output logic [IDW-1:0]              owner,
  output logic                        busy
);

  localparam int CNTW = $clog2(MAXBURST + 1);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  logic [IDW-1:0]  r_owner;
  logic [IDW-1:0]  w_owner_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;

  logic            w_busy;
  logic            w_owner_valid;
  logic            w_beat;
  logic            w_burst_end;
  logic            w_release;
  logic [IDW-1:0]  w_owner_inc;
  logic [IDW-1:0]  w_start;
  logic            w_found;
  logic [IDW-1:0]  w_pick;

  assign w_busy        = (r_state == BUSY);
  assign w_owner_valid = req_valid[r_owner];
  assign w_beat        = w_busy && w_owner_valid && !fifo_full;
  assign w_burst_end   = w_beat && (r_cnt == CNTW'(MAXBURST - 1));
  assign w_release     = w_busy && (!w_owner_valid || w_burst_end);
  assign w_owner_inc   = IDW'(rr_inc(int'(r_owner), NREQ));

  // While busy the search already starts past the owner, so a re-grant on
  // release needs no extra cycle through IDLE.
  assign w_start = w_busy ? w_owner_inc : r_ptr;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req      (req_valid),
    .start    (w_start),
    .excl_en  (w_burst_end),
    .excl_idx (r_owner),
    .found    (w_found),
    .idx      (w_pick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BUSY;
          w_owner_nxt = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (w_beat) begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
        if (w_release) begin
          w_ptr_nxt = w_owner_inc;
          w_cnt_nxt = '0;
          if (w_found) begin
            w_owner_nxt = w_pick;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (w_beat) begin
      req_ready[r_owner] = 1'b1;
    end
  end

  // Gated by busy so the bus reads zero while idle and in reset.
  assign fifo_in   = w_busy ? {r_owner, req_data[r_owner]} : '0;
  assign fifo_push = w_beat;
  assign owner     = r_owner;
  assign busy      = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_fifo_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_arbiter : directed + random checks of fifo_arbiter against a model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_arbiter;

  localparam int NA = 4, DWA = 32, MBA = 4, IDA = 2;
  localparam int NB = 3, DWB = 8,  MBB = 2, IDB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NA-1:0]          va = '0;
  logic [NA-1:0][DWA-1:0] da = '0;
  logic [NA-1:0]          ra;
  logic                   pa;
  logic [IDA+DWA-1:0]     ia;
  logic                   fa = 1'b0;
  logic [IDA-1:0]         oa;
  logic                   ba;

  logic [NB-1:0]          vb = '0;
  logic [NB-1:0][DWB-1:0] db = '0;
  logic [NB-1:0]          rb;
  logic                   pb;
  logic [IDB+DWB-1:0]     ib;
  logic                   fb = 1'b0;
  logic [IDB-1:0]         ob;
  logic                   bb;

  fifo_arbiter #(.NREQ(NA), .DWIDTH(DWA), .MAXBURST(MBA)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_valid(va), .req_data(da), .req_ready(ra),
    .fifo_push(pa), .fifo_in(ia), .fifo_full(fa), .owner(oa), .busy(ba));

  fifo_arbiter #(.NREQ(NB), .DWIDTH(DWB), .MAXBURST(MBB)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_valid(vb), .req_data(db), .req_ready(rb),
    .fifo_push(pb), .fifo_in(ib), .fifo_full(fb), .owner(ob), .busy(bb));

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;
  int gap = 0;

  int m_busy[2], m_owner[2], m_ptr[2], m_cnt[2], acc[2];

  logic [DWA-1:0]    qa[NA][$];
  logic [DWB-1:0]    qb[NB][$];
  logic [63:0]       pla[$], plb[$];
  int                pca[$], pcb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input int vec, input int start, input int n,
                              input bit ex_en, input int ex);
    for (int i = 0; i < n; i++) begin
      if (vec[(start + i) % n] && !(ex_en && ((start + i) % n) == ex)) return (start + i) % n;
    end
    if (ex_en && vec[ex]) return ex;
    return -1;
  endfunction

  // Expected outputs this cycle from the model state, then advance the model.
  task automatic model_step(input int k, input int n, input int mb, input int dw,
                            input int vec, input bit full, input logic [63:0] odata,
                            input int a_ready, input bit a_push, input logic [63:0] a_in,
                            input int a_owner, input bit a_busy);
    bit    beat, bend, rel;
    int    p;
    string pfx;
    pfx  = (k == 0) ? "a_" : "b_";
    beat = (m_busy[k] != 0) && vec[m_owner[k]] && !full;
    chk({pfx, "busy"}, 64'(a_busy), 64'(m_busy[k]));
    chk({pfx, "push"}, 64'(a_push), 64'(beat));
    chk({pfx, "ready"}, 64'(a_ready), beat ? 64'(1 << m_owner[k]) : 64'd0);
    if (m_busy[k] != 0) chk({pfx, "owner"}, 64'(a_owner), 64'(m_owner[k]));
    if (beat) chk({pfx, "fifo_in"}, a_in, (64'(m_owner[k]) << dw) | odata);
    acc[k] = beat ? (1 << m_owner[k]) : 0;
    bend = beat && (m_cnt[k] == mb - 1);
    rel  = (m_busy[k] != 0) && (!vec[m_owner[k]] || bend);
    if (m_busy[k] == 0) begin
      p = pick(vec, m_ptr[k], n, 1'b0, 0);
      if (p >= 0) begin
        m_busy[k] = 1; m_owner[k] = p; m_cnt[k] = 0;
      end
    end else begin
      if (beat) m_cnt[k]++;
      if (rel) begin
        m_ptr[k] = (m_owner[k] + 1) % n;
        p = pick(vec, m_ptr[k], n, bend, m_owner[k]);
        if (p >= 0) begin
          m_owner[k] = p; m_cnt[k] = 0;
        end else begin
          m_busy[k] = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("a_rst_busy", 64'(ba), 64'd0);
      chk("a_rst_push", 64'(pa), 64'd0);
      chk("a_rst_ready", 64'(ra), 64'd0);
      chk("a_rst_fifo_in", 64'(ia), 64'd0);
      chk("b_rst_busy", 64'(bb), 64'd0);
      chk("b_rst_push", 64'(pb), 64'd0);
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0; acc[k] = 0;
      end
    end else begin
      model_step(0, NA, MBA, DWA, int'(va), fa, 64'(da[m_owner[0]]),
                 int'(ra), pa, 64'(ia), int'(oa), ba);
      model_step(1, NB, MBB, DWB, int'(vb), fb, 64'(db[m_owner[1]]),
                 int'(rb), pb, 64'(ib), int'(ob), bb);
      if (pa) begin pla.push_back(64'(ia)); pca.push_back(cyc); end
      if (pb) begin plb.push_back(64'(ib)); pcb.push_back(cyc); end
    end
  end

  // One clock: retire accepted words, then present the next ones.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NA; i++) begin
      if (acc[0][i] && qa[i].size() > 0) void'(qa[i].pop_front());
      if (!(va[i] && !acc[0][i])) va[i] = (qa[i].size() > 0) && ($urandom_range(99) >= gap);
      da[i] = (qa[i].size() > 0) ? qa[i][0] : '0;
    end
    for (int i = 0; i < NB; i++) begin
      if (acc[1][i] && qb[i].size() > 0) void'(qb[i].pop_front());
      if (!(vb[i] && !acc[1][i])) vb[i] = (qb[i].size() > 0) && ($urandom_range(99) >= gap);
      db[i] = (qb[i].size() > 0) ? qb[i][0] : '0;
    end
  endtask

  task automatic clear_and_reset();
    for (int i = 0; i < NA; i++) qa[i].delete();
    for (int i = 0; i < NB; i++) qb[i].delete();
    va = '0; vb = '0; fa = 1'b0; fb = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    pla.delete(); pca.delete(); plb.delete(); pcb.delete();
  endtask

  task automatic wait_cnt(input int which, input int target, input int budget);
    int t;
    t = 0;
    while (((which == 0) ? pla.size() : plb.size()) < target && t < budget) begin
      step();
      t++;
    end
    chk("wait_pushes_timeout", 64'(((which == 0) ? pla.size() : plb.size()) >= target), 64'd1);
  endtask

  function automatic logic [63:0] ga(input int i);
    return (i < pla.size()) ? pla[i] : 64'hBAD0BAD0;
  endfunction
  function automatic logic [63:0] gb(input int i);
    return (i < plb.size()) ? plb[i] : 64'hBAD0BAD0;
  endfunction
  function automatic int ca(input int i);
    return (i < pca.size()) ? pca[i] : -1000;
  endfunction

  int t0, base;

  initial begin
    // Single requester: burst of 4, seamless re-grant, then 2 more words.
    clear_and_reset();
    for (int i = 0; i < 6; i++) qa[2].push_back(32'hA0 + i);
    t0 = cyc + 1;
    wait_cnt(0, 6, 40);
    for (int i = 0; i < 6; i++) chk("t1_word", ga(i), {30'd0, 2'd2, 32'hA0 + i});
    chk("t1_latency", 64'(ca(0) - t0), 64'd1);
    chk("t1_no_bubble", 64'(ca(5) - ca(0)), 64'd5);

    // Full contention: bursts of 4 rotating 0,1,2,3, then one word each.
    clear_and_reset();
    for (int i = 0; i < NA; i++)
      for (int s = 0; s < 5; s++) qa[i].push_back(32'(i * 256 + s));
    wait_cnt(0, 20, 80);
    for (int p = 0; p < 20; p++) begin
      int id, sq;
      id = (p < 16) ? p / 4 : p - 16;
      sq = (p < 16) ? p % 4 : 4;
      chk("t2_order", ga(p), (64'(id) << 32) | 64'(id * 256 + sq));
    end
    chk("t2_rate", 64'(ca(16) - ca(0)), 64'd16);

    // Backpressure: FIFO full for 5 cycles after beat 2.
    clear_and_reset();
    for (int i = 0; i < 4; i++) qa[1].push_back(32'hB0 + i);
    wait_cnt(0, 2, 20);
    fa = 1'b1;
    repeat (5) step();
    chk("t3_stall_pushes", 64'(pla.size()), 64'd2);
    chk("t3_owner", 64'(oa), 64'd1);
    chk("t3_busy", 64'(ba), 64'd1);
    fa = 1'b0;
    wait_cnt(0, 4, 20);
    chk("t3_word3", ga(2), {30'd0, 2'd1, 32'hB2});
    chk("t3_word4", ga(3), {30'd0, 2'd1, 32'hB3});
    chk("t3_gap", 64'(ca(2) - ca(1)), 64'd6);
    chk("t3_resume", 64'(ca(3) - ca(2)), 64'd1);

    // Owner drops valid after one word while requester 3 waits.
    clear_and_reset();
    qa[1].push_back(32'hC1);
    qa[3].push_back(32'hC3);
    qa[3].push_back(32'hC4);
    wait_cnt(0, 3, 20);
    chk("t4_w0", ga(0), {30'd0, 2'd1, 32'hC1});
    chk("t4_w1", ga(1), {30'd0, 2'd3, 32'hC3});
    chk("t4_lost_cycle", 64'(ca(1) - ca(0)), 64'd2);

    // Fairness wrap: A reaches ptr=3, B (NREQ=3) reaches ptr=2.
    clear_and_reset();
    qa[2].push_back(32'hD2);
    qb[1].push_back(8'h51);
    wait_cnt(0, 1, 20);
    wait_cnt(1, 1, 20);
    repeat (3) step();
    qa[0].push_back(32'hE0);
    qa[3].push_back(32'hE3);
    qb[0].push_back(8'h60);
    qb[2].push_back(8'h62);
    wait_cnt(0, 3, 20);
    wait_cnt(1, 3, 20);
    chk("t5_a_first", ga(1), {30'd0, 2'd3, 32'hE3});
    chk("t5_a_second", ga(2), {30'd0, 2'd0, 32'hE0});
    chk("t5_b_first", gb(1), {54'd0, 2'd2, 8'h62});
    chk("t5_b_second", gb(2), {54'd0, 2'd0, 8'h60});

    // Reset mid-burst (A has ptr=1 here); afterwards ptr=0 lets 0 beat 3.
    for (int i = 0; i < 4; i++) qa[3].push_back(32'hF0 + i);
    wait_cnt(0, 4, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_push", 64'(pa), 64'd0);
    chk("t6_rst_ready", 64'(ra), 64'd0);
    chk("t6_rst_busy", 64'(ba), 64'd0);
    chk("t6_rst_fifo_in", 64'(ia), 64'd0);
    qa[0].push_back(32'h55);
    step(); step();
    rst_n = 1'b1;
    base = pla.size();
    wait_cnt(0, base + 4, 30);
    chk("t6_first_after_rst", ga(base), {30'd0, 2'd0, 32'h55});
    chk("t6_resume_owner3", ga(base + 1), {30'd0, 2'd3, 32'hF1});

    // Random traffic, backpressure and occasional resets against the model.
    gap = 30;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NA; i++)
        if (qa[i].size() < 2)
          repeat ($urandom_range(6, 1)) qa[i].push_back($urandom);
      for (int i = 0; i < NB; i++)
        if (qb[i].size() < 2)
          repeat ($urandom_range(6, 1)) qb[i].push_back(8'($urandom));
      fa = ($urandom_range(99) < 25);
      fb = ($urandom_range(99) < 25);
      rst_n = ($urandom_range(499) != 0);
      step();
    end
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

`default_nettype wire
